// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG entropy path: health-monitor state
// encoding and default test cutoffs used by the monitor and its neighbours.
package trng_pkg;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        FAIL    = 2'd2
    } trng_state_e;

    localparam int unsigned WORD_W_DEF          = 32;
    localparam int unsigned RCT_CUTOFF_DEF      = 31;
    localparam int unsigned APT_WINDOW_DEF      = 512;
    localparam int unsigned APT_CUTOFF_DEF      = 325;
    localparam int unsigned STARTUP_SAMPLES_DEF = 1024;

endpackage

// File: rtl/trng_bit_packer.sv
// Serial-to-parallel packer: collects accepted bits LSB first into a word,
// hands full words to a valid/ready output register and flags samples that
// must be discarded because both the packer and the output are occupied.
module trng_bit_packer
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_i,
    input  logic              push_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic [WORD_W-1:0] word_o,
    output logic              valid_o,
    output logic              dropped_o
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              dropped_q, dropped_d;

    logic              can_load;
    logic [WORD_W-1:0] filled;

    // Next-state for shift register, bit count, output register and drop pulse
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        valid_d   = valid_q;
        dropped_d = 1'b0;
        can_load  = !valid_q || ready_i;
        filled    = shreg_q;

        for (int unsigned i = 0; i < WORD_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                filled[i] = bit_i;
            end
        end

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (flush_i) begin
            shreg_d = '0;
            cnt_d   = '0;
            out_d   = '0;
            valid_d = 1'b0;
        end else if (cnt_q == CNT_W'(WORD_W)) begin
            // Packer already full: drain it first, the new bit then starts the next word
            if (can_load) begin
                out_d   = shreg_q;
                valid_d = 1'b1;
                shreg_d = '0;
                cnt_d   = '0;
                if (push_i) begin
                    shreg_d[0] = bit_i;
                    cnt_d      = CNT_W'(1);
                end
            end else if (push_i) begin
                dropped_d = 1'b1;
            end
        end else if (push_i) begin
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
                if (can_load) begin
                    out_d   = filled;
                    valid_d = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                end else begin
                    shreg_d = filled;
                    cnt_d   = CNT_W'(WORD_W);
                end
            end else begin
                shreg_d = filled;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Packer and output register state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign word_o    = out_q;
    assign valid_o   = valid_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/trng_health_monitor.sv
// Raw TRNG health monitor: runs the repetition-count and adaptive-proportion
// tests on every sample, gates output behind a startup phase, latches
// failures until cleared and feeds accepted bits to the word packer.
module trng_health_monitor
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W          = WORD_W_DEF,
    parameter int unsigned RCT_CUTOFF      = RCT_CUTOFF_DEF,
    parameter int unsigned APT_WINDOW      = APT_WINDOW_DEF,
    parameter int unsigned APT_CUTOFF      = APT_CUTOFF_DEF,
    parameter int unsigned STARTUP_SAMPLES = STARTUP_SAMPLES_DEF
) (
    input  logic              TRNG_Clock,
    input  logic              TRNG_Reset,
    input  logic              raw_bit,
    input  logic              raw_valid,
    input  logic              clear_fail,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              rct_fail,
    output logic              apt_fail,
    output logic              startup_done,
    output logic              dropped
);

    localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned APT_W = $clog2(APT_CUTOFF + 1);
    localparam int unsigned WIN_W = $clog2(APT_WINDOW + 1);
    localparam int unsigned SU_W  = $clog2(STARTUP_SAMPLES + 1);

    trng_state_e state_q, state_d;

    logic             rct_seen_q, rct_seen_d;
    logic             rct_last_q, rct_last_d;
    logic [RCT_W-1:0] rct_run_q, rct_run_d;
    logic             apt_ref_q, apt_ref_d;
    logic [APT_W-1:0] apt_cnt_q, apt_cnt_d;
    logic [WIN_W-1:0] apt_pos_q, apt_pos_d;
    logic [SU_W-1:0]  su_cnt_q;
    logic             rct_fail_q, apt_fail_q, startup_done_q;

    logic sample_en, clear_go;
    logic rct_hit, apt_hit, fail_hit, su_last;
    logic pack_push, pack_flush;

    assign sample_en = raw_valid && (state_q != FAIL);
    assign clear_go  = (state_q == FAIL) && clear_fail;

    // Repetition count test: run length of identical consecutive samples
    always_comb begin
        rct_seen_d = rct_seen_q;
        rct_last_d = rct_last_q;
        rct_run_d  = rct_run_q;
        if (sample_en) begin
            rct_seen_d = 1'b1;
            if (!rct_seen_q || (raw_bit != rct_last_q)) begin
                rct_last_d = raw_bit;
                rct_run_d  = RCT_W'(1);
            end else if (rct_run_q != RCT_W'(RCT_CUTOFF)) begin
                rct_run_d = rct_run_q + RCT_W'(1);
            end
        end
        rct_hit = sample_en && (rct_run_d == RCT_W'(RCT_CUTOFF));
    end

    // Adaptive proportion test: occurrences of the window's first sample
    always_comb begin
        apt_ref_d = apt_ref_q;
        apt_cnt_d = apt_cnt_q;
        apt_pos_d = apt_pos_q;
        if (sample_en) begin
            if (apt_pos_q == '0) begin
                apt_ref_d = raw_bit;
                apt_cnt_d = APT_W'(1);
            end else if ((raw_bit == apt_ref_q) && (apt_cnt_q != APT_W'(APT_CUTOFF))) begin
                apt_cnt_d = apt_cnt_q + APT_W'(1);
            end
            apt_pos_d = (apt_pos_q == WIN_W'(APT_WINDOW - 1)) ? '0 : apt_pos_q + WIN_W'(1);
        end
        apt_hit  = sample_en && (apt_cnt_d == APT_W'(APT_CUTOFF));
        fail_hit = rct_hit || apt_hit;
        su_last  = (state_q == STARTUP) && sample_en && !fail_hit &&
                   (su_cnt_q == SU_W'(STARTUP_SAMPLES - 1));
    end

    // Health-test counters; a clear from FAIL restarts them like a reset
    always_ff @(posedge TRNG_Clock) begin
        if (TRNG_Reset || clear_go) begin
            rct_seen_q <= 1'b0;
            rct_last_q <= 1'b0;
            rct_run_q  <= '0;
            apt_ref_q  <= 1'b0;
            apt_cnt_q  <= '0;
            apt_pos_q  <= '0;
            su_cnt_q   <= '0;
        end else begin
            rct_seen_q <= rct_seen_d;
            rct_last_q <= rct_last_d;
            rct_run_q  <= rct_run_d;
            apt_ref_q  <= apt_ref_d;
            apt_cnt_q  <= apt_cnt_d;
            apt_pos_q  <= apt_pos_d;
            if ((state_q == STARTUP) && sample_en && !fail_hit &&
                (su_cnt_q != SU_W'(STARTUP_SAMPLES))) begin
                su_cnt_q <= su_cnt_q + SU_W'(1);
            end
        end
    end

    // Latched failure flags and startup status
    always_ff @(posedge TRNG_Clock) begin
        if (TRNG_Reset || clear_go) begin
            rct_fail_q     <= 1'b0;
            apt_fail_q     <= 1'b0;
            startup_done_q <= 1'b0;
        end else begin
            if (rct_hit) rct_fail_q <= 1'b1;
            if (apt_hit) apt_fail_q <= 1'b1;
            if (su_last) startup_done_q <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge TRNG_Clock) begin
        if (TRNG_Reset) begin
            state_q <= STARTUP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            STARTUP: begin
                if (fail_hit)     state_d = FAIL;
                else if (su_last) state_d = RUN;
            end
            RUN: begin
                if (fail_hit) state_d = FAIL;
            end
            FAIL: begin
                if (clear_fail) state_d = STARTUP;
            end
            default: state_d = STARTUP;
        endcase
    end

    // FSM outputs: the failing sample is flushed together with the packer
    always_comb begin
        pack_push  = (state_q == RUN) && raw_valid && !fail_hit;
        pack_flush = fail_hit || (state_q == FAIL);
    end

    trng_bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk_i     (TRNG_Clock),
        .rst_i     (TRNG_Reset),
        .bit_i     (raw_bit),
        .push_i    (pack_push),
        .flush_i   (pack_flush),
        .ready_i   (word_ready),
        .word_o    (word_out),
        .valid_o   (word_valid),
        .dropped_o (dropped)
    );

    assign rct_fail     = rct_fail_q;
    assign apt_fail     = apt_fail_q;
    assign startup_done = startup_done_q;

endmodule

// File: tb/tb_trng_health_monitor.sv
// Self-checking bench for trng_health_monitor with small cutoffs.
module tb_trng_health_monitor;

    localparam int unsigned W = 8;

    logic         TRNG_Clock = 1'b0;
    logic         TRNG_Reset = 1'b1;
    logic         raw_bit    = 1'b0;
    logic         raw_valid  = 1'b0;
    logic         clear_fail = 1'b0;
    logic         word_ready = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid, rct_fail, apt_fail, startup_done, dropped;

    always #5 TRNG_Clock = ~TRNG_Clock;

    trng_health_monitor #(
        .WORD_W          (8),
        .RCT_CUTOFF      (4),
        .APT_WINDOW      (16),
        .APT_CUTOFF      (12),
        .STARTUP_SAMPLES (16)
    ) dut (
        .TRNG_Clock   (TRNG_Clock),
        .TRNG_Reset   (TRNG_Reset),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .clear_fail   (clear_fail),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .rct_fail     (rct_fail),
        .apt_fail     (apt_fail),
        .startup_done (startup_done),
        .dropped      (dropped)
    );

    typedef struct {
        bit [47:0] nm;
        bit        rst, b, v, r, c;
        bit        ev, cw;
        logic [7:0] ew;
        bit        er, ea, es, ed;
        bit        push;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          e_rct = 0, e_apt = 0, e_sd = 0, e_drop = 0;

    function automatic void add(bit [47:0] nm, bit rst, bit b, bit v, bit r, bit c,
                                bit ev, logic [7:0] ew, bit push);
        vec_t t;
        t.nm = nm; t.rst = rst; t.b = b; t.v = v; t.r = r; t.c = c;
        t.ev = ev; t.cw = ev | rst; t.ew = ew;
        t.er = e_rct; t.ea = e_apt; t.es = e_sd; t.ed = e_drop;
        t.push = push;
        vecs.push_back(t);
    endfunction

    // Drive one cycle; a word seen with valid&ready before the edge is delivered.
    task automatic drive(input bit rst_v, input bit b, input bit v, input bit r, input bit c);
        logic [7:0] exp_w;
        @(negedge TRNG_Clock);
        TRNG_Reset = rst_v;
        raw_bit    = b;
        raw_valid  = v;
        word_ready = r;
        clear_fail = c;
        if (!rst_v && word_valid && word_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL handshake: word_out=%h delivered, no word expected", word_out);
            end else begin
                exp_w = sb.pop_front();
                if (word_out === exp_w) n_pass++;
                else $display("FAIL handshake: word_out=%h expected %h", word_out, exp_w);
            end
        end
        @(posedge TRNG_Clock);
        #1;
    endtask

    task automatic check(input bit [47:0] nm, input int idx, input bit ev, input bit cw,
                         input logic [7:0] ew, input bit er, input bit ea, input bit es,
                         input bit ed);
        logic [12:0] act, exp;
        act = {word_valid, rct_fail, apt_fail, startup_done, dropped, (cw ? word_out : 8'h00)};
        exp = {ev, er, ea, es, ed, (cw ? ew : 8'h00)};
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got v=%b rct=%b apt=%b sd=%b drop=%b word=%h, want v=%b rct=%b apt=%b sd=%b drop=%b word=%h",
                     nm, idx, act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    initial begin
        logic [8:0] rseq;
        rseq = 9'b111101110;

        // Reset
        add("rst", 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("rst", 1, 0, 0, 0, 0, 0, 8'h00, 0);
        // Startup with alternating samples, then first word 0xAA
        for (int i = 0; i < 16; i++) begin
            e_sd = (i == 15);
            add("suA", 0, i[0], 1, 1, 0, 0, 8'h00, 0);
        end
        for (int i = 0; i < 8; i++) add("runA", 0, i[0], 1, 1, 0, (i == 7), 8'hAA, (i == 7));
        add("idleA", 0, 0, 0, 1, 0, 0, 8'h00, 0);
        // RCT: 0,1,1,1,0 passes, then four 1s fail; word 0xEE handshaked on the failing edge
        for (int i = 0; i < 9; i++) begin
            e_rct = (i == 8);
            add("rct", 0, rseq[i], 1, 1, 0, (i == 7), 8'hEE, (i == 7));
        end
        for (int i = 0; i < 3; i++) add("ign", 0, 1, 1, 1, 0, 0, 8'h00, 0);
        e_rct = 0; e_sd = 0;
        add("clr", 0, 0, 0, 1, 1, 0, 8'h00, 0);
        // Startup again, starting with 1 so the APT run does not extend an RCT run
        for (int i = 0; i < 16; i++) begin
            e_sd = (i == 15);
            add("suB", 0, !i[0], 1, 1, 0, 0, 8'h00, 0);
        end
        // APT: 1,1,1,0 repeated; 12th reference hit on the 15th sample of the window
        for (int i = 0; i < 15; i++) begin
            e_apt = (i == 14);
            add("apt", 0, ((i % 4) != 3), 1, 1, 0, (i == 7), 8'h77, (i == 7));
        end
        e_apt = 0; e_sd = 0;
        add("clr2", 0, 0, 0, 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            e_sd = (i == 15);
            add("suC", 0, i[0], 1, 0, 0, 0, 8'h00, 0);
        end
        // Backpressure: first word held, packer fills, 17th sample dropped
        for (int i = 0; i < 17; i++) begin
            e_drop = (i == 16);
            add("bp", 0, i[0], 1, 0, 0, (i >= 7), 8'hAA, (i == 7) || (i == 15));
        end
        e_drop = 0;
        add("bpr1", 0, 0, 0, 1, 0, 1, 8'hAA, 0);
        add("bpr2", 0, 0, 0, 1, 0, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) sb.push_back(vecs[i].ew);
            drive(vecs[i].rst, vecs[i].b, vecs[i].v, vecs[i].r, vecs[i].c);
            check(vecs[i].nm, i, vecs[i].ev, vecs[i].cw, vecs[i].ew,
                  vecs[i].er, vecs[i].ea, vecs[i].es, vecs[i].ed);
        end

        // Reset mid-stream while a word is valid, with clear_fail and ready also high
        for (int i = 0; i < 8; i++) begin
            drive(0, i[0], 1, 0, 0);
            check("hold", i, (i == 7), (i == 7), 8'hAA, 0, 0, 1, 0);
        end
        drive(1, 1, 1, 1, 1);
        check("mrst", 0, 0, 1, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, i[0], 1, 1, 0);
            check("suD", i, 0, 0, 8'h00, 0, 0, (i == 15), 0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) sb.push_back(8'hAA);
            drive(0, i[0], 1, 1, 0);
            check("runD", i, (i == 7), (i == 7), 8'hAA, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 1, 0);
        check("idleD", 0, 0, 0, 8'h00, 0, 0, 1, 0);

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_empty: %0d words outstanding, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trng_health_monitor.md
# trng_health_monitor

Parametrised health-test and word-packing stage that sits between a raw TRNG entropy source and its consumers (hash conditioner, UART, buffer). It runs two SP800-90B continuous health tests on every raw sample: the Repetition Count Test (RCT) and the Adaptive Proportion Test (APT). Cutoffs and window size are parameters. The block enforces a startup test phase, latches failures until explicitly cleared, and packs accepted bits into WORD_W-bit words behind a valid/ready output.

## Interface
- WORD_W, 32, bits per output word (≥2)
- RCT_CUTOFF, 31, run length of identical samples that triggers RCT failure (≥2)
- APT_WINDOW, 512, samples per APT window (≥2)
- APT_CUTOFF, 325, count of the reference value within one window that triggers APT failure (2..APT_WINDOW)
- STARTUP_SAMPLES, 1024, failure-free samples required before any output (≥1)

Ports:
- TRNG_Clock  in  1  single clock; all logic on rising edge
- TRNG_Reset  in  1  synchronous, active-high reset
- raw_bit  in  1  entropy sample
- raw_valid  in  1  raw_bit is a new sample this cycle
- clear_fail  in  1  pulse: leave FAIL, restart startup phase
- word_out  out  WORD_W  packed word; sample k of the word is at bit k (LSB first)
- word_valid  out  1  word_out holds an undelivered word
- word_ready  in  1  consumer accepts word_out
- rct_fail  out  1  latched RCT failure
- apt_fail  out  1  latched APT failure
- startup_done  out  1  startup phase passed
- dropped  out  1  one-cycle pulse: accepted-state sample discarded due to backpressure

## Operation
- States: STARTUP, RUN, FAIL. Reset enters STARTUP. All outputs are 0 after reset. Counters are cleared.
- Health tests see every sample with raw_valid=1, in all states except FAIL. This includes samples that are dropped or discarded during startup.
- RCT:
  - The first sample after reset or clear sets last=bit and run=1.
  - A later sample equal to last increments run. A differing sample sets run=1 and last=bit.
  - When run reaches RCT_CUTOFF, rct_fail is raised.
- APT:
  - The first sample of a window is the reference, with count=1.
  - Each later sample in the window equal to the reference increments count.
  - When count reaches APT_CUTOFF, apt_fail is raised.
  - After APT_WINDOW samples, the next sample starts a new window.
- Any failure in STARTUP or RUN moves the block to FAIL. In FAIL:
  - the packer is cleared;
  - word_valid is cleared and any held word is discarded;
  - samples are ignored.
- clear_fail in FAIL moves the block to STARTUP. It clears rct_fail, apt_fail, startup_done, and the RCT/APT/startup counters. clear_fail is ignored in other states.
- STARTUP:
  - Samples are tested but not packed.
  - After STARTUP_SAMPLES samples with no failure, startup_done is set and the state becomes RUN.
  - The last startup sample is not packed.
- RUN:
  - Each sample that does not trigger a failure shifts into the packer at position count.
  - When the packer holds WORD_W bits, the word moves to the output register if it is empty or being consumed this cycle; the packer then restarts at 0.
  - If the output register is held (word_valid=1, word_ready=0) and the packer is full, the incoming sample is dropped and dropped pulses. The sample is still health-tested. The packer keeps its contents.
- The sample that triggers a failure is never packed.
- Counter widths are $clog2(limit+1). Counters saturate at their cutoff; no wrap.

## Timing
- word_valid rises the cycle after the raw_valid cycle carrying the word's WORD_W-th bit.
- A transfer occurs on any cycle with word_valid & word_ready. word_valid falls the next cycle unless a new word loads the same cycle (back-to-back, no bubble).
- A failing sample at cycle t gives fail flag=1, state=FAIL and word_valid=0 at t+1. A transfer handshaked at t still counts as delivered.
- startup_done rises the cycle after the STARTUP_SAMPLES-th sample.
- dropped pulses at the cycle after the dropped sample.
- Reset mid-operation overrides everything, including a simultaneous clear_fail or handshake.

## Structure
- Shared package trng_pkg:
  - state enum (STARTUP, RUN, FAIL);
  - default cutoff constants (RCT 31, APT 512/325, startup 1024), reused by the hash conditioner and top-level.
- Sub-module trng_bit_packer contains:
  - the shift register and bit counter;
  - the output holding register;
  - valid/ready and drop logic.
- Its inputs are bit, push, flush. The health FSM and tests stay in the parent.

## Test plan
Parameters for all scenarios: WORD_W=8, RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=12, STARTUP_SAMPLES=16.

- Reset mid-stream with word_valid=1 -> next cycle all outputs 0; first 16 samples after reset produce no word.
- 16 alternating startup samples, then samples 0,1,0,1,0,1,0,1 with word_ready=1 -> startup_done=1, word_out=0xAA, word_valid high exactly one cycle, one cycle after the 8th sample.
- In RUN: 0,1,1,1,0 -> no failure. Then 1,1,1,1 -> rct_fail=1 one cycle after the 4th 1; apt_fail=0; word_valid=0; later samples ignored.
- In RUN at a window start: repeat 1,1,1,0 -> apt_fail=1 one cycle after the window's 15th sample (12th 1); rct_fail=0.
- word_ready=0 after startup, 17 alternating samples -> first word held, packer full after sample 16, dropped pulses once for sample 17. Then word_ready=1 -> 0xAA delivered, then the second word back-to-back.
- After a failure, clear_fail pulse -> flags and startup_done clear next cycle. startup_done returns only after 16 more failure-free samples.
